// File: rtl/rv32i_decode_exec_regfile.sv
// rv32i_decode_exec_regfile
//   Datapath core of the multi-cycle RV32I CPU: registered instruction
//   decoder, 32x32 register file and registered execute unit.
//
// Ports
//   clk                 rising-edge clock
//   rstn                asynchronous reset, active HIGH despite the name
//   state               control FSM state code (decode / execute strobes)
//   instr_raw, pc       fetched instruction word and its address
//   w_enable/addr/data  register file write port (x0 writes ignored)
//   rd, rs1, rs2, imm   decoded register indices and sign-extended immediate
//   rs1_v, rs2_v        combinational register reads of decoded rs1/rs2
//   ls_funct3           funct3 of the current load/store
//   illegal             decoded word is not an RV32I base instruction
//   result              ALU / address / link result
//   mem_read_enabled    instruction is a load
//   mem_write_enabled   instruction is a store
//   reg_write_enabled   instruction writes rd
//   reg_write_dest      destination register
//   is_jump_enabled     PC redirect required
//   jump_dest           redirect target
module rv32i_decode_exec_regfile #(
  parameter int unsigned          STATE_W   = 3,
  parameter logic [STATE_W-1:0]   DECODE_ST = STATE_W'(1),
  parameter logic [STATE_W-1:0]   EXEC_ST   = STATE_W'(2)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [STATE_W-1:0] state,
  input  logic [31:0]        instr_raw,
  input  logic [31:0]        pc,
  input  logic               w_enable,
  input  logic [4:0]         w_addr,
  input  logic [31:0]        w_data,
  output logic [4:0]         rd,
  output logic [4:0]         rs1,
  output logic [4:0]         rs2,
  output logic [31:0]        imm,
  output logic [31:0]        rs1_v,
  output logic [31:0]        rs2_v,
  output logic [2:0]         ls_funct3,
  output logic               illegal,
  output logic [31:0]        result,
  output logic               mem_read_enabled,
  output logic               mem_write_enabled,
  output logic               reg_write_enabled,
  output logic [4:0]         reg_write_dest,
  output logic               is_jump_enabled,
  output logic [31:0]        jump_dest
);

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OPIMM  = 7'b0010011,
    OPC_OP     = 7'b0110011
  } opcode_e;

  // Bit positions inside the one-hot operation flag vector. Register-immediate
  // ALU forms share the flag of their register form; alu_imm selects imm as
  // the second operand.
  typedef enum logic [4:0] {
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LOAD, OP_STORE,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_COUNT
  } op_e;

  // ---------------------------------------------------------------- decode
  logic [4:0]          rd_q, rs1_q, rs2_q;
  logic [2:0]          funct3_q;
  logic [31:0]         imm_q, imm_d;
  logic [OP_COUNT-1:0] op_q, op_d;
  logic                alu_imm_q, alu_imm_d;
  logic                illegal_q, illegal_d;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opc = instr_raw[6:0];
  assign f3  = instr_raw[14:12];
  assign f7  = instr_raw[31:25];

  assign imm_i = {{20{instr_raw[31]}}, instr_raw[31:20]};
  assign imm_s = {{20{instr_raw[31]}}, instr_raw[31:25], instr_raw[11:7]};
  assign imm_b = {{19{instr_raw[31]}}, instr_raw[31], instr_raw[7],
                  instr_raw[30:25], instr_raw[11:8], 1'b0};
  assign imm_u = {instr_raw[31:12], 12'b0};
  assign imm_j = {{11{instr_raw[31]}}, instr_raw[31], instr_raw[19:12],
                  instr_raw[20], instr_raw[30:21], 1'b0};

  always_comb begin
    op_d      = '0;
    alu_imm_d = 1'b0;
    illegal_d = 1'b0;
    imm_d     = '0;
    case (opc)
      OPC_LUI: begin
        op_d[OP_LUI] = 1'b1;
        imm_d        = imm_u;
      end
      OPC_AUIPC: begin
        op_d[OP_AUIPC] = 1'b1;
        imm_d          = imm_u;
      end
      OPC_JAL: begin
        op_d[OP_JAL] = 1'b1;
        imm_d        = imm_j;
      end
      OPC_JALR: begin
        if (f3 == 3'b000) begin
          op_d[OP_JALR] = 1'b1;
          imm_d         = imm_i;
        end else begin
          illegal_d = 1'b1;
        end
      end
      OPC_BRANCH: begin
        imm_d = imm_b;
        case (f3)
          3'b000:  op_d[OP_BEQ]  = 1'b1;
          3'b001:  op_d[OP_BNE]  = 1'b1;
          3'b100:  op_d[OP_BLT]  = 1'b1;
          3'b101:  op_d[OP_BGE]  = 1'b1;
          3'b110:  op_d[OP_BLTU] = 1'b1;
          3'b111:  op_d[OP_BGEU] = 1'b1;
          default: begin
            illegal_d = 1'b1;
            imm_d     = '0;
          end
        endcase
      end
      OPC_LOAD: begin
        if (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 ||
            f3 == 3'b100 || f3 == 3'b101) begin
          op_d[OP_LOAD] = 1'b1;
          imm_d         = imm_i;
        end else begin
          illegal_d = 1'b1;
        end
      end
      OPC_STORE: begin
        if (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010) begin
          op_d[OP_STORE] = 1'b1;
          imm_d          = imm_s;
        end else begin
          illegal_d = 1'b1;
        end
      end
      OPC_OPIMM: begin
        alu_imm_d = 1'b1;
        imm_d     = imm_i;
        case (f3)
          3'b000: op_d[OP_ADD]  = 1'b1;
          3'b010: op_d[OP_SLT]  = 1'b1;
          3'b011: op_d[OP_SLTU] = 1'b1;
          3'b100: op_d[OP_XOR]  = 1'b1;
          3'b110: op_d[OP_OR]   = 1'b1;
          3'b111: op_d[OP_AND]  = 1'b1;
          3'b001: begin
            if (f7 == 7'b0000000) op_d[OP_SLL] = 1'b1;
            else                  illegal_d    = 1'b1;
          end
          default: begin // 3'b101
            if      (f7 == 7'b0000000) op_d[OP_SRL] = 1'b1;
            else if (f7 == 7'b0100000) op_d[OP_SRA] = 1'b1;
            else                       illegal_d    = 1'b1;
          end
        endcase
        if (illegal_d) begin
          alu_imm_d = 1'b0;
          imm_d     = '0;
        end
      end
      OPC_OP: begin
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000:  op_d[OP_ADD]  = 1'b1;
            3'b001:  op_d[OP_SLL]  = 1'b1;
            3'b010:  op_d[OP_SLT]  = 1'b1;
            3'b011:  op_d[OP_SLTU] = 1'b1;
            3'b100:  op_d[OP_XOR]  = 1'b1;
            3'b101:  op_d[OP_SRL]  = 1'b1;
            3'b110:  op_d[OP_OR]   = 1'b1;
            default: op_d[OP_AND]  = 1'b1;
          endcase
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          op_d[OP_SUB] = 1'b1;
        end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
          op_d[OP_SRA] = 1'b1;
        end else begin
          illegal_d = 1'b1;
        end
      end
      default: illegal_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      funct3_q  <= '0;
      imm_q     <= '0;
      op_q      <= '0;
      alu_imm_q <= 1'b0;
      illegal_q <= 1'b0;
    end else if (state == DECODE_ST) begin
      rd_q      <= instr_raw[11:7];
      rs1_q     <= instr_raw[19:15];
      rs2_q     <= instr_raw[24:20];
      funct3_q  <= f3;
      imm_q     <= imm_d;
      op_q      <= op_d;
      alu_imm_q <= alu_imm_d;
      illegal_q <= illegal_d;
    end
  end

  // ---------------------------------------------------------- register file
  logic [31:0] regs_q [32];

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      for (int unsigned i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (w_enable && (w_addr != 5'd0)) begin
      regs_q[w_addr] <= w_data;
    end
  end

  assign rs1_v = (rs1_q == 5'd0) ? '0 : regs_q[rs1_q];
  assign rs2_v = (rs2_q == 5'd0) ? '0 : regs_q[rs2_q];

  // ---------------------------------------------------------------- execute
  logic [31:0] result_q, result_d;
  logic        mrd_q, mrd_d, mwr_q, mwr_d, rwe_q, rwe_d, jmp_q, jmp_d;
  logic [4:0]  rdest_q;
  logic [31:0] jdest_q, jdest_d;

  logic [31:0] opa, opb, link, pc_rel;
  logic [4:0]  shamt;

  assign opa    = rs1_v;
  assign opb    = alu_imm_q ? imm_q : rs2_v;
  assign shamt  = opb[4:0];
  assign link   = pc + 32'd4;
  assign pc_rel = pc + imm_q;

  always_comb begin
    result_d = '0;
    mrd_d    = 1'b0;
    mwr_d    = 1'b0;
    rwe_d    = 1'b0;
    jmp_d    = 1'b0;
    jdest_d  = '0;
    case (1'b1)
      op_q[OP_ADD]:  begin result_d = opa + opb;                     rwe_d = 1'b1; end
      op_q[OP_SUB]:  begin result_d = opa - opb;                     rwe_d = 1'b1; end
      op_q[OP_AND]:  begin result_d = opa & opb;                     rwe_d = 1'b1; end
      op_q[OP_OR]:   begin result_d = opa | opb;                     rwe_d = 1'b1; end
      op_q[OP_XOR]:  begin result_d = opa ^ opb;                     rwe_d = 1'b1; end
      op_q[OP_SLL]:  begin result_d = opa << shamt;                  rwe_d = 1'b1; end
      op_q[OP_SRL]:  begin result_d = opa >> shamt;                  rwe_d = 1'b1; end
      op_q[OP_SRA]:  begin result_d = 32'($signed(opa) >>> shamt);   rwe_d = 1'b1; end
      op_q[OP_SLT]:  begin result_d = {31'b0, $signed(opa) < $signed(opb)}; rwe_d = 1'b1; end
      op_q[OP_SLTU]: begin result_d = {31'b0, opa < opb};            rwe_d = 1'b1; end
      op_q[OP_LUI]:  begin result_d = imm_q;                         rwe_d = 1'b1; end
      op_q[OP_AUIPC]: begin result_d = pc_rel;                       rwe_d = 1'b1; end
      op_q[OP_JAL]: begin
        result_d = link;
        rwe_d    = 1'b1;
        jmp_d    = 1'b1;
        jdest_d  = pc_rel;
      end
      op_q[OP_JALR]: begin
        result_d = link;
        rwe_d    = 1'b1;
        jmp_d    = 1'b1;
        jdest_d  = (opa + imm_q) & ~32'd1;
      end
      op_q[OP_BEQ]:  begin jdest_d = pc_rel; jmp_d = (opa == rs2_v); end
      op_q[OP_BNE]:  begin jdest_d = pc_rel; jmp_d = (opa != rs2_v); end
      op_q[OP_BLT]:  begin jdest_d = pc_rel; jmp_d = ($signed(opa) <  $signed(rs2_v)); end
      op_q[OP_BGE]:  begin jdest_d = pc_rel; jmp_d = ($signed(opa) >= $signed(rs2_v)); end
      op_q[OP_BLTU]: begin jdest_d = pc_rel; jmp_d = (opa <  rs2_v); end
      op_q[OP_BGEU]: begin jdest_d = pc_rel; jmp_d = (opa >= rs2_v); end
      op_q[OP_LOAD]: begin
        result_d = opa + imm_q;
        mrd_d    = 1'b1;
        rwe_d    = 1'b1;
      end
      op_q[OP_STORE]: begin
        result_d = opa + imm_q;
        mwr_d    = 1'b1;
      end
      default: ; // illegal or idle: everything stays 0
    endcase
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      result_q <= '0;
      mrd_q    <= 1'b0;
      mwr_q    <= 1'b0;
      rwe_q    <= 1'b0;
      jmp_q    <= 1'b0;
      rdest_q  <= '0;
      jdest_q  <= '0;
    end else if (state == EXEC_ST) begin
      result_q <= result_d;
      mrd_q    <= mrd_d;
      mwr_q    <= mwr_d;
      rwe_q    <= rwe_d;
      jmp_q    <= jmp_d;
      rdest_q  <= rd_q;
      jdest_q  <= jdest_d;
    end
  end

  assign rd                = rd_q;
  assign rs1               = rs1_q;
  assign rs2               = rs2_q;
  assign imm               = imm_q;
  assign ls_funct3         = funct3_q;
  assign illegal           = illegal_q;
  assign result            = result_q;
  assign mem_read_enabled  = mrd_q;
  assign mem_write_enabled = mwr_q;
  assign reg_write_enabled = rwe_q;
  assign reg_write_dest    = rdest_q;
  assign is_jump_enabled   = jmp_q;
  assign jump_dest         = jdest_q;

endmodule

// File: tb/tb_rv32i_decode_exec_regfile.sv
// Directed bench for rv32i_decode_exec_regfile: hand-computed vectors
// checked with immediate assertions.
module tb_rv32i_decode_exec_regfile;

  localparam logic [2:0] ST_FETCH = 3'd0;
  localparam logic [2:0] ST_DEC   = 3'd1;
  localparam logic [2:0] ST_EXEC  = 3'd2;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [2:0]  state = ST_FETCH;
  logic [31:0] instr_raw = '0;
  logic [31:0] pc = '0;
  logic        w_enable = 1'b0;
  logic [4:0]  w_addr = '0;
  logic [31:0] w_data = '0;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm, rs1_v, rs2_v;
  logic [2:0]  ls_funct3;
  logic        illegal;
  logic [31:0] result;
  logic        mem_read_enabled, mem_write_enabled, reg_write_enabled;
  logic [4:0]  reg_write_dest;
  logic        is_jump_enabled;
  logic [31:0] jump_dest;

  int n_checks = 0;
  int n_fail   = 0;

  rv32i_decode_exec_regfile #(
    .STATE_W  (3),
    .DECODE_ST(3'd1),
    .EXEC_ST  (3'd2)
  ) dut (
    .clk              (clk),
    .rstn             (rstn),
    .state            (state),
    .instr_raw        (instr_raw),
    .pc               (pc),
    .w_enable         (w_enable),
    .w_addr           (w_addr),
    .w_data           (w_data),
    .rd               (rd),
    .rs1              (rs1),
    .rs2              (rs2),
    .imm              (imm),
    .rs1_v            (rs1_v),
    .rs2_v            (rs2_v),
    .ls_funct3        (ls_funct3),
    .illegal          (illegal),
    .result           (result),
    .mem_read_enabled (mem_read_enabled),
    .mem_write_enabled(mem_write_enabled),
    .reg_write_enabled(reg_write_enabled),
    .reg_write_dest   (reg_write_dest),
    .is_jump_enabled  (is_jump_enabled),
    .jump_dest        (jump_dest)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $fatal(1, "FAIL timeout: simulation did not finish, %0d checks done", n_checks);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [2:0] st, input logic [31:0] ins, input logic [31:0] p);
    @(negedge clk);
    state     = st;
    instr_raw = ins;
    pc        = p;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    state    = ST_FETCH;
    w_enable = 1'b1;
    w_addr   = a;
    w_data   = d;
    @(posedge clk);
    #1;
    w_enable = 1'b0;
  endtask

  logic [31:0] ins;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("por_result", result, 32'h0);
    chk("por_imm", imm, 32'h0);
    chk("por_rd", 32'(rd), 32'd0);
    chk("por_illegal", 32'(illegal), 32'd0);
    chk("por_rwe", 32'(reg_write_enabled), 32'd0);
    chk("por_jdest", jump_dest, 32'h0);
    @(negedge clk);
    rstn = 1'b0;

    for (int unsigned i = 1; i < 32; i++) wr(5'(i), 32'h1000 + 32'(i));

    wr(5'd1, 32'd5);
    wr(5'd2, 32'd7);
    cyc(ST_DEC, 32'h002081B3, 32'h0);
    chk("add_rd", 32'(rd), 32'd3);
    chk("add_rs1", 32'(rs1), 32'd1);
    chk("add_rs2", 32'(rs2), 32'd2);
    chk("add_imm", imm, 32'h0);
    chk("add_rs1_v", rs1_v, 32'd5);
    chk("add_rs2_v", rs2_v, 32'd7);
    chk("add_illegal", 32'(illegal), 32'd0);
    cyc(ST_EXEC, 32'h0, 32'h0);
    chk("add_result", result, 32'd12);
    chk("add_rwe", 32'(reg_write_enabled), 32'd1);
    chk("add_dest", 32'(reg_write_dest), 32'd3);
    chk("add_mrd", 32'(mem_read_enabled), 32'd0);
    chk("add_mwr", 32'(mem_write_enabled), 32'd0);
    chk("add_jmp", 32'(is_jump_enabled), 32'd0);

    cyc(ST_FETCH, 32'hFFFFFFFF, 32'h0);
    chk("hold_result", result, 32'd12);
    chk("hold_rd", 32'(rd), 32'd3);

    @(negedge clk);
    state = ST_EXEC;
    #2 rstn = 1'b1;
    #1;
    chk("arst_result", result, 32'h0);
    chk("arst_rwe", 32'(reg_write_enabled), 32'd0);
    chk("arst_dest", 32'(reg_write_dest), 32'd0);
    chk("arst_rd", 32'(rd), 32'd0);
    chk("arst_rs1", 32'(rs1), 32'd0);
    chk("arst_rs2", 32'(rs2), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    state = ST_FETCH;
    rstn  = 1'b0;
    for (int unsigned i = 0; i < 32; i++) begin
      ins = {7'b0, 5'(i), 5'(i), 3'b000, 5'b0, 7'b0110011};
      cyc(ST_DEC, ins, 32'h0);
      chk("arst_rs1_v", rs1_v, 32'h0);
      chk("arst_rs2_v", rs2_v, 32'h0);
    end

    wr(5'd1, 32'd9);
    wr(5'd2, 32'd9);
    cyc(ST_DEC, 32'h00208463, 32'h40);
    chk("beq_imm", imm, 32'd8);
    cyc(ST_EXEC, 32'h0, 32'h40);
    chk("beq_jmp", 32'(is_jump_enabled), 32'd1);
    chk("beq_jdest", jump_dest, 32'h48);
    chk("beq_result", result, 32'h0);
    chk("beq_rwe", 32'(reg_write_enabled), 32'd0);
    wr(5'd2, 32'd8);
    cyc(ST_EXEC, 32'h0, 32'h40);
    chk("beq_nt_jmp", 32'(is_jump_enabled), 32'd0);
    chk("beq_nt_jdest", jump_dest, 32'h48);

    wr(5'd2, 32'h100);
    cyc(ST_DEC, 32'hFFC12283, 32'h0);
    chk("lw_imm", imm, 32'hFFFFFFFC);
    chk("lw_f3", 32'(ls_funct3), 32'd2);
    cyc(ST_EXEC, 32'h0, 32'h0);
    chk("lw_result", result, 32'hFC);
    chk("lw_mrd", 32'(mem_read_enabled), 32'd1);
    chk("lw_mwr", 32'(mem_write_enabled), 32'd0);
    chk("lw_rwe", 32'(reg_write_enabled), 32'd1);
    chk("lw_dest", 32'(reg_write_dest), 32'd5);

    cyc(ST_DEC, 32'h003100E7, 32'h20);
    cyc(ST_EXEC, 32'h0, 32'h20);
    chk("jalr_jdest", jump_dest, 32'h102);
    chk("jalr_result", result, 32'h24);
    chk("jalr_jmp", 32'(is_jump_enabled), 32'd1);
    chk("jalr_rwe", 32'(reg_write_enabled), 32'd1);

    cyc(ST_DEC, 32'h010000EF, 32'h40);
    chk("jal_imm", imm, 32'd16);
    cyc(ST_EXEC, 32'h0, 32'h40);
    chk("jal_jdest", jump_dest, 32'h50);
    chk("jal_result", result, 32'h44);

    cyc(ST_DEC, 32'h123452B7, 32'h0);
    chk("lui_imm", imm, 32'h12345000);
    cyc(ST_EXEC, 32'h0, 32'h0);
    chk("lui_result", result, 32'h12345000);
    chk("lui_jmp", 32'(is_jump_enabled), 32'd0);

    wr(5'd1, 32'hFFFFFFF0);
    wr(5'd2, 32'd4);
    cyc(ST_DEC, 32'h4020D1B3, 32'h0);
    cyc(ST_EXEC, 32'h0, 32'h0);
    chk("sra_result", result, 32'hFFFFFFFF);
    cyc(ST_DEC, 32'h0020A1B3, 32'h0);
    cyc(ST_EXEC, 32'h0, 32'h0);
    chk("slt_result", result, 32'd1);
    cyc(ST_DEC, 32'h0020B1B3, 32'h0);
    cyc(ST_EXEC, 32'h0, 32'h0);
    chk("sltu_result", result, 32'd0);

    cyc(ST_DEC, 32'h003100E7, 32'h20);
    cyc(ST_EXEC, 32'h0, 32'h20);
    wr(5'd0, 32'hDEADBEEF);
    cyc(ST_DEC, 32'h00000000, 32'h0);
    chk("x0_rs1_v", rs1_v, 32'h0);
    chk("ill_flag", 32'(illegal), 32'd1);
    cyc(ST_EXEC, 32'h0, 32'h0);
    chk("ill_result", result, 32'h0);
    chk("ill_rwe", 32'(reg_write_enabled), 32'd0);
    chk("ill_mrd", 32'(mem_read_enabled), 32'd0);
    chk("ill_mwr", 32'(mem_write_enabled), 32'd0);
    chk("ill_jmp", 32'(is_jump_enabled), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
